// File: rtl/prienc_arb.sv
// Registered 1-of-N request encoder: fixed-priority (highest index wins) or round-robin,
// with the grant held in an output register under a valid/ready handshake.
module prienc_arb #(
    parameter int  N = 12,
    localparam int W = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_req,
    input  logic         i_rr,
    input  logic         i_clr,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_idx,
    output logic [N-1:0] o_onehot,
    output logic         o_match
);

    logic [W-1:0] ptr;
    logic [N-1:0] lo_mask;
    logic [N-1:0] lo_req;
    logic [W-1:0] sel;
    logic         load;

    function automatic logic [W-1:0] top_idx(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (v[i]) r = W'(i);
        return r;
    endfunction

    // RR search runs ptr-1 down to 0 first, then wraps to N-1 down to ptr:
    // the highest request below ptr wins, else the highest request overall.
    always_comb begin
        lo_mask = '0;
        for (int i = 0; i < N; i++)
            lo_mask[i] = (i < int'(ptr));
        lo_req = i_req & lo_mask;
        sel    = (i_rr && |lo_req) ? top_idx(lo_req) : top_idx(i_req);
    end

    assign load    = ~o_valid | i_ready;
    assign o_match = |i_req;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid  <= 1'b0;
            o_idx    <= '0;
            o_onehot <= '0;
            ptr      <= '0;
        end else if (i_clr) begin
            o_valid  <= 1'b0;
            o_idx    <= '0;
            o_onehot <= '0;
        end else if (load) begin
            if (|i_req) begin
                o_valid  <= 1'b1;
                o_idx    <= sel;
                o_onehot <= N'(1) << sel;
                ptr      <= sel;
            end else begin
                o_valid  <= 1'b0;
                o_idx    <= '0;
                o_onehot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prienc_arb.sv
// Directed bench for prienc_arb at N=12: reset, fixed priority, hold, round-robin,
// single requester, flush vs reset pointer behaviour.
module tb_prienc_arb;

    localparam int N = 12;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         reset, rr, clr, ready;
    logic [N-1:0] req;
    logic         valid, match;
    logic [W-1:0] idx;
    logic [N-1:0] onehot;

    int tests = 0;
    int fails = 0;

    prienc_arb #(.N(N)) dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_rr(rr), .i_clr(clr),
        .i_ready(ready), .o_valid(valid), .o_idx(idx), .o_onehot(onehot), .o_match(match)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; clr = 1'b0; rr = 1'b0; ready = 1'b0; req = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (valid !== 1'b0 || idx !== 4'd0 || onehot !== 12'h000 || match !== 1'b0) begin
            fails++;
            $display("FAIL reset: valid=%b idx=%0d onehot=%h match=%b, want 0/0/000/0",
                     valid, idx, onehot, match);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if (valid !== 1'b0 || idx !== 4'd0 || onehot !== 12'h000) begin
                fails++;
                $display("FAIL reset_hold[%0d]: valid=%b idx=%0d onehot=%h, want 0/0/000",
                         c, valid, idx, onehot);
            end
        end
    endtask

    task automatic test_fixed();
        logic [N-1:0] vec [3];
        logic [W-1:0] exp_i [3];
        logic [N-1:0] exp_oh [3];
        vec = '{12'h0A4, 12'h024, 12'h004};
        exp_i = '{4'd7, 4'd5, 4'd2};
        exp_oh = '{12'h080, 12'h020, 12'h004};
        do_reset();
        rr = 1'b0; ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req = vec[k];
            #1;
            tests++;
            if (match !== 1'b1) begin
                fails++;
                $display("FAIL fixed_match[%0d]: got %b want 1", k, match);
            end
            step();
            tests++;
            if (valid !== 1'b1 || idx !== exp_i[k] || onehot !== exp_oh[k]) begin
                fails++;
                $display("FAIL fixed[%0d]: valid=%b idx=%0d onehot=%h, want 1/%0d/%h",
                         k, valid, idx, onehot, exp_i[k], exp_oh[k]);
            end
        end
        req = '0;
        step();
        tests++;
        if (valid !== 1'b0 || idx !== 4'd0 || onehot !== 12'h000) begin
            fails++;
            $display("FAIL fixed_empty: valid=%b idx=%0d onehot=%h, want 0/0/000", valid, idx, onehot);
        end
    endtask

    task automatic test_hold();
        do_reset();
        rr = 1'b0; ready = 1'b0; req = 12'h801;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) req = '0;
            // toggling mode while held must not disturb the grant
            rr = c[0];
            step();
            tests++;
            if (valid !== 1'b1 || idx !== 4'd11 || onehot !== 12'h800) begin
                fails++;
                $display("FAIL hold[%0d]: valid=%b idx=%0d onehot=%h, want 1/11/800",
                         c, valid, idx, onehot);
            end
        end
        ready = 1'b1;
        step();
        tests++;
        if (valid !== 1'b0 || idx !== 4'd0) begin
            fails++;
            $display("FAIL hold_release: valid=%b idx=%0d, want 0/0", valid, idx);
        end
    endtask

    task automatic test_rr_rotate();
        logic [W-1:0] seq [6];
        seq = '{4'd11, 4'd7, 4'd4, 4'd0, 4'd11, 4'd7};
        do_reset();
        rr = 1'b1; ready = 1'b1; req = 12'h891;
        for (int k = 0; k < 6; k++) begin
            step();
            tests++;
            if (valid !== 1'b1 || idx !== seq[k] || onehot !== (12'h001 << seq[k])) begin
                fails++;
                $display("FAIL rr_rotate[%0d]: valid=%b idx=%0d onehot=%h, want 1/%0d",
                         k, valid, idx, onehot, seq[k]);
            end
        end
    endtask

    // continues from test_rr_rotate: last grant 7 held, ready=1
    task automatic test_back_to_back();
        logic [W-1:0] seq [6];
        seq = '{4'd4, 4'd4, 4'd4, 4'd3, 4'd4, 4'd3};
        rr = 1'b1; ready = 1'b1; req = 12'h010;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) req = 12'h018;
            step();
            tests++;
            if (valid !== 1'b1 || idx !== seq[k]) begin
                fails++;
                $display("FAIL back_to_back[%0d]: valid=%b idx=%0d, want 1/%0d", k, valid, idx, seq[k]);
            end
        end
    endtask

    task automatic test_clr_vs_reset();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            rr = 1'b0; ready = 1'b0; req = 12'h200;
            step();
            tests++;
            if (valid !== 1'b1 || idx !== 4'd9) begin
                fails++;
                $display("FAIL flush_setup[%0d]: valid=%b idx=%0d, want 1/9", pass, valid, idx);
            end
            req = 12'h3FF; rr = 1'b1; ready = 1'b1;
            if (pass == 0) clr = 1'b1; else reset = 1'b1;
            step();
            tests++;
            if (valid !== 1'b0 || idx !== 4'd0 || onehot !== 12'h000) begin
                fails++;
                $display("FAIL flush[%0d]: valid=%b idx=%0d onehot=%h, want 0/0/000",
                         pass, valid, idx, onehot);
            end
            clr = 1'b0; reset = 1'b0;
            step();
            tests++;
            if (valid !== 1'b1 || idx !== (pass == 0 ? 4'd8 : 4'd9)) begin
                fails++;
                $display("FAIL flush_next[%0d]: valid=%b idx=%0d, want 1/%0d",
                         pass, valid, idx, (pass == 0 ? 8 : 9));
            end
        end
    endtask

    initial begin
        reset = 1'b1; rr = 1'b0; clr = 1'b0; ready = 1'b0; req = '0;
        test_reset();
        test_fixed();
        test_hold();
        test_rr_rotate();
        test_back_to_back();
        test_clr_vs_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
